// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants and stage record layout for the
// ID/EX, EX/MEM and MEM/WB control registers.
package pipe_ctrl_pkg;

  localparam int OPW   = 6;
  localparam int FUNCW = 6;
  localparam int REGW  = 5;
  localparam int CNTW  = 16;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_J     = 6'h02;
  localparam logic [OPW-1:0] OP_JAL   = 6'h03;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_BNE   = 6'h05;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic             valid;
    logic [OPW-1:0]   opcode;
    logic [FUNCW-1:0] func;
    logic [REGW-1:0]  rt;
  } stage_t;

  localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One pipeline control register; a bubble is all-zero,
// so reset and squash load the same value.
module pipe_ctrl_stage #(
  parameter int W = 18
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Carries ID opcode/func down to WB, detects load-use hazards
// and MEM-resolved redirects, and counts stall/flush cycles.
module pipe_ctrl_regs
  import pipe_ctrl_pkg::*;
#(
  parameter int              OPW         = pipe_ctrl_pkg::OPW,
  parameter int              FUNCW       = pipe_ctrl_pkg::FUNCW,
  parameter int              REGW        = pipe_ctrl_pkg::REGW,
  parameter int              CNTW        = pipe_ctrl_pkg::CNTW,
  parameter logic [OPW-1:0]  LOAD_OPCODE = OP_LW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [OPW-1:0]   id_opcode,
  input  logic [FUNCW-1:0] id_func,
  input  logic [REGW-1:0]  id_rs,
  input  logic [REGW-1:0]  id_rt,
  input  logic [1:0]       pcSrc,
  output logic [OPW-1:0]   ex_opcode,
  output logic [FUNCW-1:0] ex_func,
  output logic [OPW-1:0]   mem_opcode,
  output logic [FUNCW-1:0] mem_func,
  output logic [OPW-1:0]   rb_opcode,
  output logic             rb_valid,
  output logic             stall,
  output logic             flush,
  output logic [CNTW-1:0]  stall_count,
  output logic [CNTW-1:0]  flush_count
);

  localparam int EXW  = 1 + OPW + FUNCW + REGW;
  localparam int MEMW = 1 + OPW + FUNCW;
  localparam int WBW  = 1 + OPW;

  logic [EXW-1:0]  ex_q;
  logic [MEMW-1:0] mem_q;
  logic [WBW-1:0]  wb_q;
  logic            ex_valid;
  logic [REGW-1:0] ex_rt;
  logic            ldhaz;

  assign ex_valid   = ex_q[EXW-1];
  assign ex_opcode  = ex_q[EXW-2 -: OPW];
  assign ex_func    = ex_q[REGW +: FUNCW];
  assign ex_rt      = ex_q[REGW-1:0];
  assign mem_opcode = mem_q[MEMW-2 -: OPW];
  assign mem_func   = mem_q[FUNCW-1:0];
  assign rb_valid   = wb_q[WBW-1];
  assign rb_opcode  = wb_q[OPW-1:0];

  assign ldhaz = ex_valid & (ex_opcode == LOAD_OPCODE) & id_valid
               & (ex_rt != '0)
               & ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Flush wins: the load sitting in EX is squashed anyway.
  assign flush = ~hold & (pcSrc != 2'b00);
  assign stall = ~hold & ~flush & ldhaz;

  pipe_ctrl_stage #(.W(EXW)) u_id_ex (
    .clock   (clock),
    .reset_n (reset_n),
    .hold    (hold),
    .clear   (flush | stall | ~id_valid),
    .d       ({id_valid, id_opcode, id_func, id_rt}),
    .q       (ex_q)
  );

  pipe_ctrl_stage #(.W(MEMW)) u_ex_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .hold    (hold),
    .clear   (flush),
    .d       (ex_q[EXW-1:REGW]),
    .q       (mem_q)
  );

  pipe_ctrl_stage #(.W(WBW)) u_mem_wb (
    .clock   (clock),
    .reset_n (reset_n),
    .hold    (hold),
    .clear   (1'b0),
    .d       (mem_q[MEMW-1:FUNCW]),
    .q       (wb_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed bench for pipe_ctrl_regs: reset, latency, load-use,
// redirect, hold and counter saturation (narrow-counter instance).
module tb_pipe_ctrl_regs;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       hold;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [5:0] id_func;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [1:0] pcSrc;

  logic [5:0]  ex_opcode, ex_func, mem_opcode, mem_func, rb_opcode;
  logic        rb_valid, stall, flush;
  logic [15:0] stall_count, flush_count;

  logic        s_valid;
  logic [5:0]  s_ex_op, s_ex_fn, s_mem_op, s_mem_fn, s_rb_op;
  logic        s_rb_valid, s_stall, s_flush;
  logic [3:0]  s_stall_count, s_flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_ctrl_regs dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .hold        (hold),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_func     (id_func),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .pcSrc       (pcSrc),
    .ex_opcode   (ex_opcode),
    .ex_func     (ex_func),
    .mem_opcode  (mem_opcode),
    .mem_func    (mem_func),
    .rb_opcode   (rb_opcode),
    .rb_valid    (rb_valid),
    .stall       (stall),
    .flush       (flush),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  pipe_ctrl_regs #(.CNTW(4)) u_sat (
    .clock       (clock),
    .reset_n     (reset_n),
    .hold        (1'b0),
    .id_valid    (s_valid),
    .id_opcode   (6'h23),
    .id_func     (6'h00),
    .id_rs       (5'd5),
    .id_rt       (5'd5),
    .pcSrc       (2'b00),
    .ex_opcode   (s_ex_op),
    .ex_func     (s_ex_fn),
    .mem_opcode  (s_mem_op),
    .mem_func    (s_mem_fn),
    .rb_opcode   (s_rb_op),
    .rb_valid    (s_rb_valid),
    .stall       (s_stall),
    .flush       (s_flush),
    .stall_count (s_stall_count),
    .flush_count (s_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [5:0] op,
                          input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt);
    id_valid  = v;
    id_opcode = op;
    id_func   = fn;
    id_rs     = rs;
    id_rt     = rt;
  endtask

  initial begin
    reset_n = 1'b0;
    hold    = 1'b0;
    pcSrc   = 2'b00;
    s_valid = 1'b0;
    drive_id(1'b1, 6'h2B, 6'h3F, 5'd3, 5'd4);
    #3;
    chk("rst_ex_op", 32'(ex_opcode), 32'h0);
    chk("rst_rb_valid", 32'(rb_valid), 32'h0);
    chk("rst_stall_cnt", 32'(stall_count), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    tick();
    tick();
    chk("rst_hold_mem", 32'(mem_opcode), 32'h0);

    // release reset mid-low-phase; first edge after it loads beq
    @(negedge clock);
    reset_n = 1'b1;
    drive_id(1'b1, 6'h04, 6'h00, 5'd1, 5'd2);
    tick();
    chk("lat_ex", 32'(ex_opcode), 32'h04);
    drive_id(1'b0, 6'h3F, 6'h3F, 5'd0, 5'd0);
    tick();
    chk("lat_mem", 32'(mem_opcode), 32'h04);
    chk("lat_ex_bubble", 32'(ex_opcode), 32'h0);
    tick();
    chk("lat_rb", 32'(rb_opcode), 32'h04);
    chk("lat_rb_valid", 32'(rb_valid), 32'h1);

    // load-use: lw r5 in EX, add using r5 in ID
    drive_id(1'b1, 6'h23, 6'h00, 5'd0, 5'd5);
    tick();
    drive_id(1'b1, 6'h00, 6'h20, 5'd5, 5'd7);
    #1;
    chk("lu_stall", 32'(stall), 32'h1);
    chk("lu_flush", 32'(flush), 32'h0);
    tick();
    chk("lu_ex_bubble", 32'(ex_opcode), 32'h0);
    chk("lu_mem_lw", 32'(mem_opcode), 32'h23);
    chk("lu_stall_cnt", 32'(stall_count), 32'h1);
    chk("lu_stall_gone", 32'(stall), 32'h0);
    tick();
    chk("lu_replay_func", 32'(ex_func), 32'h20);
    chk("lu_replay_op", 32'(ex_opcode), 32'h00);

    // load to r0 never stalls
    drive_id(1'b1, 6'h23, 6'h00, 5'd0, 5'd0);
    tick();
    drive_id(1'b1, 6'h00, 6'h20, 5'd0, 5'd0);
    #1;
    chk("r0_stall", 32'(stall), 32'h0);
    tick();
    chk("r0_stall_cnt", 32'(stall_count), 32'h1);

    // redirect overrides a simultaneous load-use
    drive_id(1'b1, 6'h02, 6'h00, 5'd0, 5'd0);
    tick();
    drive_id(1'b1, 6'h23, 6'h00, 5'd0, 5'd6);
    tick();
    chk("rd_mem_j", 32'(mem_opcode), 32'h02);
    drive_id(1'b1, 6'h00, 6'h22, 5'd6, 5'd1);
    pcSrc = 2'b10;
    #1;
    chk("rd_flush", 32'(flush), 32'h1);
    chk("rd_no_stall", 32'(stall), 32'h0);
    tick();
    pcSrc = 2'b00;
    chk("rd_ex_bubble", 32'({ex_opcode, ex_func}), 32'h0);
    chk("rd_mem_bubble", 32'({mem_opcode, mem_func}), 32'h0);
    chk("rd_rb_j", 32'(rb_opcode), 32'h02);
    chk("rd_flush_cnt", 32'(flush_count), 32'h1);
    chk("rd_stall_cnt", 32'(stall_count), 32'h1);

    // hold freezes everything, even with a pending redirect
    drive_id(1'b1, 6'h04, 6'h00, 5'd1, 5'd2);
    tick();
    drive_id(1'b1, 6'h05, 6'h00, 5'd1, 5'd2);
    tick();
    drive_id(1'b1, 6'h2B, 6'h00, 5'd1, 5'd2);
    hold  = 1'b1;
    pcSrc = 2'b01;
    #1;
    chk("hd_flush", 32'(flush), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hd_ex", 32'(ex_opcode), 32'h05);
      chk("hd_mem", 32'(mem_opcode), 32'h04);
      chk("hd_rb_valid", 32'(rb_valid), 32'h0);
      chk("hd_flush_cnt", 32'(flush_count), 32'h1);
    end
    hold = 1'b0;
    #1;
    chk("hd_drop_flush", 32'(flush), 32'h1);
    tick();
    pcSrc = 2'b00;
    chk("hd_ex_bubble", 32'(ex_opcode), 32'h0);
    chk("hd_rb_beq", 32'(rb_opcode), 32'h04);
    chk("hd_rb_valid2", 32'(rb_valid), 32'h1);
    chk("hd_flush_cnt2", 32'(flush_count), 32'h2);

    // asynchronous reset mid-stream
    drive_id(1'b1, 6'h03, 6'h00, 5'd0, 5'd0);
    tick();
    chk("mr_ex_pre", 32'(ex_opcode), 32'h03);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_ex", 32'(ex_opcode), 32'h0);
    chk("mr_mem", 32'(mem_opcode), 32'h0);
    chk("mr_rb", 32'({rb_valid, rb_opcode}), 32'h0);
    chk("mr_counts", 32'({stall_count, flush_count}), 32'h0);
    chk("mr_stall", 32'(stall), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    drive_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);

    // saturation on the 4-bit-counter instance
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_mid", 32'(s_stall_count), 32'h3);
    for (int i = 0; i < 34; i++) tick();
    chk("sat_full", 32'(s_stall_count), 32'hF);
    tick();
    tick();
    chk("sat_stays", 32'(s_stall_count), 32'hF);
    chk("sat_no_flush", 32'(s_flush_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
